// File: rtl/sdram_device_model.sv
// Behavioural SDR SDRAM for controller simulation: JEDEC command decode, word
// array with byte masks, a single burst engine and a CAS-latency read pipeline.
module sdram_device_model #(
    parameter int                  DATA_BITS = 16,
    parameter int                  BANK_BITS = 2,
    parameter int                  ROW_BITS  = 12,
    parameter int                  COL_BITS  = 8,
    parameter logic [ROW_BITS-1:0] MODE_RST  = 'h033
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Cke,
    input  logic                   Cs_n,
    input  logic                   Ras_n,
    input  logic                   Cas_n,
    input  logic                   We_n,
    input  logic [BANK_BITS-1:0]   Ba,
    input  logic [ROW_BITS-1:0]    Addr,
    input  logic [DATA_BITS/8-1:0] Dqm,
    inout  wire  [DATA_BITS-1:0]   Dq,
    output logic                   Err
);

    localparam int LANES = DATA_BITS / 8;
    localparam int AW    = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int NBANK = 1 << BANK_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} burst_state_t;
    burst_state_t state_q, state_d;

    logic [DATA_BITS-1:0] mem [0:(1<<AW)-1];

    logic [NBANK-1:0]     bank_open;
    logic [ROW_BITS-1:0]  row_q [NBANK];
    logic [2:0]           mode_bl;
    logic                 mode_il, mode_cl3, mode_wsingle;

    logic [BANK_BITS-1:0] burst_bank;
    logic [ROW_BITS-1:0]  burst_row;
    logic [COL_BITS-1:0]  burst_col, burst_k, burst_mask;
    logic                 burst_full, burst_il, burst_ap;

    logic                 vld_p0, vld_p1, vld_p2;
    logic [DATA_BITS-1:0] data_p0, data_p1, data_p2;
    logic [LANES-1:0]     dqm_p0, dqm_p1;

    function automatic logic [COL_BITS-1:0] bl_mask_f(input logic [2:0] bl);
        case (bl)
            3'd0:    return '0;
            3'd1:    return COL_BITS'(1);
            3'd2:    return COL_BITS'(3);
            3'd3:    return COL_BITS'(7);
            3'd7:    return '1;
            default: return '0;
        endcase
    endfunction

    // Low bits inside the burst window advance (sequential) or are XORed (interleaved).
    function automatic logic [COL_BITS-1:0] burst_col_f(input logic [COL_BITS-1:0] start,
                                                        input logic [COL_BITS-1:0] k,
                                                        input logic [COL_BITS-1:0] mask,
                                                        input logic            il);
        logic [COL_BITS-1:0] low;
        low = il ? (start ^ k) : (start + k);
        return (start & ~mask) | (low & mask);
    endfunction

    logic cmd_en, is_act, is_rd, is_wr, is_pre, is_lmr, is_bst;
    assign cmd_en = Cke && !Cs_n;
    assign is_act = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b011);
    assign is_rd  = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b101);
    assign is_wr  = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b100);
    assign is_pre = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b010);
    assign is_lmr = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b000);
    assign is_bst = cmd_en && ({Ras_n, Cas_n, We_n} == 3'b110);

    logic bank_hit, any_open, rd_ok, wr_ok, pre_hit, stop_burst, adv, last;
    assign bank_hit   = bank_open[Ba];
    assign any_open   = |bank_open;
    assign rd_ok      = is_rd && bank_hit;
    assign wr_ok      = is_wr && bank_hit;
    assign pre_hit    = is_pre && (state_q != ST_IDLE) && (Addr[10] || (Ba == burst_bank));
    assign stop_burst = rd_ok || wr_ok || is_bst || pre_hit;
    assign adv        = Cke && (state_q != ST_IDLE) && !stop_burst;
    assign last       = adv && !burst_full && (burst_k == burst_mask);

    logic                wr_single, cmd_full, cmd_single;
    logic [COL_BITS-1:0] cmd_mask;
    assign wr_single  = is_wr && mode_wsingle;
    assign cmd_mask   = wr_single ? '0 : bl_mask_f(mode_bl);
    assign cmd_full   = !wr_single && (mode_bl == 3'd7);
    assign cmd_single = (cmd_mask == '0) && !cmd_full;

    logic [AW-1:0]        cmd_idx, eng_idx, acc_idx;
    logic                 rd_issue, wr_en;
    logic [DATA_BITS-1:0] rd_word;
    assign cmd_idx  = {Ba, row_q[Ba], Addr[COL_BITS-1:0]};
    assign eng_idx  = {burst_bank, burst_row, burst_col_f(burst_col, burst_k, burst_mask, burst_il)};
    assign acc_idx  = (rd_ok || wr_ok) ? cmd_idx : eng_idx;
    assign rd_issue = rd_ok || (adv && (state_q == ST_READ));
    assign wr_en    = wr_ok || (adv && (state_q == ST_WRITE));
    assign rd_word  = mem[acc_idx];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rd_ok || wr_ok) begin
            if (cmd_single) state_d = ST_IDLE;
            else            state_d = rd_ok ? ST_READ : ST_WRITE;
        end else if (stop_burst || last) begin
            state_d = ST_IDLE;
        end
    end

    // Array write: word 0 on the command edge, later words as the engine advances.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!Dqm[i]) mem[acc_idx][8*i +: 8] <= Dq[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bank_open    <= '0;
            for (int b = 0; b < NBANK; b++) row_q[b] <= '0;
            mode_bl      <= MODE_RST[2:0];
            mode_il      <= MODE_RST[3];
            mode_cl3     <= (MODE_RST[6:4] == 3'd3);
            mode_wsingle <= MODE_RST[9];
            burst_bank   <= '0;
            burst_row    <= '0;
            burst_col    <= '0;
            burst_k      <= '0;
            burst_mask   <= '0;
            burst_full   <= 1'b0;
            burst_il     <= 1'b0;
            burst_ap     <= 1'b0;
            Err          <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
        end else begin
            if (adv) burst_k <= burst_k + COL_BITS'(1);
            if (last && burst_ap) bank_open[burst_bank] <= 1'b0;
            if (rd_ok || wr_ok) begin
                burst_bank <= Ba;
                burst_row  <= row_q[Ba];
                burst_col  <= Addr[COL_BITS-1:0];
                burst_k    <= COL_BITS'(1);
                burst_mask <= cmd_mask;
                burst_full <= cmd_full;
                burst_il   <= mode_il && !cmd_full;
                burst_ap   <= Addr[10];
                if (cmd_single && Addr[10]) bank_open[Ba] <= 1'b0;
            end
            if ((is_rd || is_wr) && !bank_hit) Err <= 1'b1;
            if (is_act) begin
                if (bank_hit) begin
                    Err <= 1'b1;
                end else begin
                    bank_open[Ba] <= 1'b1;
                    row_q[Ba]     <= Addr;
                end
            end
            if (is_pre) begin
                if (Addr[10]) bank_open     <= '0;
                else          bank_open[Ba] <= 1'b0;
            end
            if (is_lmr) begin
                if (any_open) begin
                    Err <= 1'b1;
                end else begin
                    mode_bl      <= Addr[2:0];
                    mode_il      <= Addr[3];
                    mode_cl3     <= (Addr[6:4] == 3'd3);
                    mode_wsingle <= Addr[9];
                end
            end
            // Read pipeline: CL3 enters at p0, CL2 at p1; p2 drives Dq.
            if (Cke) begin
                vld_p0 <= rd_issue && mode_cl3;
                vld_p1 <= (rd_issue && !mode_cl3) || (vld_p0 && !stop_burst);
                vld_p2 <= vld_p1 && !stop_burst;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Cke) begin
            data_p0 <= rd_word;
            data_p1 <= (rd_issue && !mode_cl3) ? rd_word : data_p0;
            data_p2 <= data_p1;
            dqm_p0  <= Dqm;
            dqm_p1  <= dqm_p0;
        end
    end

    // Output stage: byte lanes masked by Dqm from two edges earlier.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign Dq[8*i +: 8] = (vld_p2 && !dqm_p1[i]) ? data_p2[8*i +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model; the data bus idles high through tri1.
module tb_sdram_device_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [11:0] addr = '0;
    logic [1:0]  dqm = '0;
    logic [15:0] dq_drv = '0;
    logic        dq_oe = 1'b0;
    logic        err;
    tri1  [15:0] dq;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] IDLE_BUS = 16'hFFFF;
    localparam logic [2:0]  C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100;
    localparam logic [2:0]  C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_BST = 3'b110;

    assign dq = dq_oe ? dq_drv : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_device_model dut (
        .Clk   (clk),
        .Rst   (rst),
        .Cke   (cke),
        .Cs_n  (cs_n),
        .Ras_n (ras_n),
        .Cas_n (cas_n),
        .We_n  (we_n),
        .Ba    (ba),
        .Addr  (addr),
        .Dqm   (dqm),
        .Dq    (dq),
        .Err   (err)
    );

    // Present a command from one falling edge to the next; on return dq shows
    // the value the device drives for the following rising edge.
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba   = b;
        addr = a;
        @(negedge clk);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic nop();
        drive(C_NOP, 2'd0, 12'h000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL reset_dq: got %h want %h", dq, IDLE_BUS); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [15:0] exp;
        drive(C_LMR, 2'd0, 12'h033);
        drive(C_ACT, 2'd1, 12'h004);
        for (int k = 0; k < 8; k++) begin
            dq_oe  = 1'b1;
            dq_drv = 16'(32'h1122 + 32'(k) * 32'h1111);
            drive((k == 0) ? C_WR : C_NOP, 2'd1, 12'h000);
        end
        dq_oe = 1'b0;
        drive(C_REF, 2'd0, 12'h000);
        nop();
        drive(C_RD, 2'd1, 12'h000);
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL wr_rd_t1: got %h want %h", dq, IDLE_BUS); end
        nop();
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL wr_rd_t2: got %h want %h", dq, IDLE_BUS); end
        for (int k = 0; k < 8; k++) begin
            nop();
            exp = 16'(32'h1122 + 32'(k) * 32'h1111);
            total++;
            if (dq !== exp) begin bad++; $display("FAIL wr_rd_word%0d: got %h want %h", k, dq, exp); end
        end
        nop();
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL wr_rd_t11: got %h want %h", dq, IDLE_BUS); end
    endtask

    task automatic test_burst_order();
        int          seq_ord [8] = '{6, 7, 0, 1, 2, 3, 4, 5};
        int          il_ord  [8] = '{6, 7, 4, 5, 2, 3, 0, 1};
        logic [15:0] exp;
        drive(C_RD, 2'd1, 12'h006);
        nop();
        for (int k = 0; k < 8; k++) begin
            nop();
            exp = 16'(32'h1122 + 32'(seq_ord[k]) * 32'h1111);
            total++;
            if (dq !== exp) begin bad++; $display("FAIL seq_word%0d: got %h want %h", k, dq, exp); end
        end
        repeat (2) nop();
        drive(C_PRE, 2'd0, 12'h400);
        drive(C_LMR, 2'd0, 12'h03B);
        drive(C_ACT, 2'd1, 12'h004);
        drive(C_RD, 2'd1, 12'h006);
        nop();
        for (int k = 0; k < 8; k++) begin
            nop();
            exp = 16'(32'h1122 + 32'(il_ord[k]) * 32'h1111);
            total++;
            if (dq !== exp) begin bad++; $display("FAIL il_word%0d: got %h want %h", k, dq, exp); end
        end
        repeat (2) nop();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL order_err: got %b want 0", err); end
    endtask

    task automatic test_dqm();
        drive(C_PRE, 2'd0, 12'h400);
        drive(C_LMR, 2'd0, 12'h233);
        drive(C_ACT, 2'd1, 12'h004);
        dq_oe  = 1'b1;
        dq_drv = 16'h1234;
        dqm    = 2'b00;
        drive(C_WR, 2'd1, 12'h010);
        dq_drv = 16'hAAAA;
        dqm    = 2'b10;
        drive(C_WR, 2'd1, 12'h010);
        dq_oe  = 1'b0;
        dqm    = 2'b00;
        drive(C_RD, 2'd1, 12'h010);
        nop();
        nop();
        total++;
        if (dq !== 16'h12AA) begin bad++; $display("FAIL dqm_write: got %h want 12aa", dq); end
        drive(C_RD, 2'd1, 12'h010);
        dqm = 2'b11;
        nop();
        dqm = 2'b00;
        nop();
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL dqm_read_mask: got %h want %h", dq, IDLE_BUS); end
        repeat (10) nop();
    endtask

    task automatic test_cl2_bst();
        drive(C_PRE, 2'd0, 12'h400);
        drive(C_LMR, 2'd0, 12'h023);
        drive(C_ACT, 2'd1, 12'h004);
        drive(C_RD, 2'd1, 12'h000);
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL cl2_t1: got %h want %h", dq, IDLE_BUS); end
        nop();
        total++;
        if (dq !== 16'h1122) begin bad++; $display("FAIL cl2_word0: got %h want 1122", dq); end
        nop();
        total++;
        if (dq !== 16'h2233) begin bad++; $display("FAIL cl2_word1: got %h want 2233", dq); end
        drive(C_BST, 2'd0, 12'h000);
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL bst_t4: got %h want %h", dq, IDLE_BUS); end
        nop();
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL bst_t5: got %h want %h", dq, IDLE_BUS); end
        repeat (2) nop();
    endtask

    task automatic test_err();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err); end
        drive(C_RD, 2'd2, 12'h000);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_idle_read: got %b want 1", err); end
        for (int k = 0; k < 3; k++) begin
            nop();
            total++;
            if (dq !== IDLE_BUS) begin bad++; $display("FAIL err_dq%0d: got %h want %h", k, dq, IDLE_BUS); end
        end
        repeat (3) nop();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_burst();
        drive(C_RD, 2'd1, 12'h000);
        nop();
        total++;
        if (dq !== 16'h1122) begin bad++; $display("FAIL rst_pre_word0: got %h want 1122", dq); end
        rst = 1'b1;
        #1;
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL rst_dq_release: got %h want %h", dq, IDLE_BUS); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err_clear: got %b want 0", err); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(C_ACT, 2'd1, 12'h004);
        drive(C_LMR, 2'd0, 12'h023);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL lmr_open_err: got %b want 1", err); end
        drive(C_RD, 2'd1, 12'h002);
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL post_rst_t1: got %h want %h", dq, IDLE_BUS); end
        nop();
        total++;
        if (dq !== IDLE_BUS) begin bad++; $display("FAIL post_rst_t2: got %h want %h", dq, IDLE_BUS); end
        nop();
        total++;
        if (dq !== 16'h3344) begin bad++; $display("FAIL post_rst_word0: got %h want 3344", dq); end
        nop();
        total++;
        if (dq !== 16'h4455) begin bad++; $display("FAIL post_rst_word1: got %h want 4455", dq); end
        repeat (8) nop();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_order();
        test_dqm();
        test_cl2_bst();
        test_err();
        test_reset_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
